// File: rtl/chia_xung_lt.sv
// chia_xung_lt: programmable glitch-free clock/pulse divider with shadowed period/high-time,
// enable, phase-sync clear and terminal-count tick.
module chia_xung_lt #(
    parameter int unsigned      WIDTH        = 31,
    parameter logic [WIDTH-1:0] DIV_DEFAULT  = 50000000,
    parameter logic [WIDTH-1:0] HIGH_DEFAULT = 25000000
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             clko,
    output logic             tick,
    output logic             pend
);
    logic [WIDTH-1:0] cnt_q, cnt_d, p_act_q, p_act_d, h_act_q, h_act_d, p_sh_q, p_sh_d, h_sh_q, h_sh_d;
    logic             pend_q, pend_d, clko_q, clko_d, tick_q, tick_d;
    logic             wrap, apply;
    assign wrap  = en && (cnt_q == p_act_q);
    assign apply = wrap || sync || !en;
    always_comb begin
        p_sh_d  = load ? div_in : p_sh_q;
        h_sh_d  = load ? high_in : h_sh_q;
        // a load landing on an apply edge bypasses the shadow stage entirely
        p_act_d = (load && apply) ? div_in : (pend_q && apply) ? p_sh_q : p_act_q;
        h_act_d = (load && apply) ? high_in : (pend_q && apply) ? h_sh_q : h_act_q;
        pend_d  = apply ? 1'b0 : (load || pend_q);
        cnt_d   = (sync || wrap) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
        clko_d  = en && (cnt_q < h_act_q);
        tick_d  = wrap && !sync;
    end
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            p_act_q <= DIV_DEFAULT;
            h_act_q <= HIGH_DEFAULT;
            p_sh_q  <= '0;
            h_sh_q  <= '0;
            pend_q  <= 1'b0;
            clko_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            p_act_q <= p_act_d;
            h_act_q <= h_act_d;
            p_sh_q  <= p_sh_d;
            h_sh_q  <= h_sh_d;
            pend_q  <= pend_d;
            clko_q  <= clko_d;
            tick_q  <= tick_d;
        end
    end
    assign clko = clko_q;
    assign tick = tick_q;
    assign pend = pend_q;
endmodule

// File: tb/tb_chia_xung_lt.sv
// tb_chia_xung_lt: directed self-checking bench for chia_xung_lt with small defaults (P=3, H=2).
module tb_chia_xung_lt;
    localparam int W = 8;
    logic clki = 1'b0, rst = 1'b1, en = 1'b0, sync = 1'b0, load = 1'b0;
    logic [W-1:0] div_in = '0, high_in = '0;
    logic clko, tick, pend;
    int checks = 0, errors = 0;

    chia_xung_lt #(.WIDTH(W), .DIV_DEFAULT(8'd3), .HIGH_DEFAULT(8'd2)) dut (
        .clki(clki), .rst(rst), .en(en), .sync(sync), .load(load),
        .div_in(div_in), .high_in(high_in), .clko(clko), .tick(tick), .pend(pend)
    );

    always #5 clki = ~clki;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic run(input string tag, input int n, input logic [15:0] ec, input logic [15:0] et);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s.clko[%0d]", tag, i), clko, ec[i]);
            chk($sformatf("%s.tick[%0d]", tag, i), tick, et[i]);
            chk($sformatf("%s.pend[%0d]", tag, i), pend, 1'b0);
        end
    endtask

    task automatic setv(input logic s, input logic l, input logic [W-1:0] d, input logic [W-1:0] h);
        sync = s; load = l; div_in = d; high_in = h;
    endtask

    initial begin
        #12;
        chk("rst.clko", clko, 1'b0);
        chk("rst.tick", tick, 1'b0);
        chk("rst.pend", pend, 1'b0);
        @(negedge clki);
        rst = 1'b0;
        en = 1'b1;
        run("t1", 8, 16'b00110011, 16'b10001000);
        // mid-period load at cnt=1 waits for the wrap
        step();
        setv(1'b0, 1'b1, 8'd4, 8'd1);
        step();
        chk("t2.pend_set", pend, 1'b1);
        chk("t2.old_clko", clko, 1'b1);
        setv(1'b0, 1'b0, 8'd0, 8'd0);
        step();
        chk("t2.pend_hold", pend, 1'b1);
        chk("t2.old_clko2", clko, 1'b0);
        step();
        chk("t2.wrap_tick", tick, 1'b1);
        chk("t2.wrap_pend", pend, 1'b0);
        run("t2", 5, 16'b00001, 16'b10000);
        // sync plus load at cnt=2
        step();
        step();
        setv(1'b1, 1'b1, 8'd2, 8'd2);
        step();
        chk("t3.tick", tick, 1'b0);
        chk("t3.pend", pend, 1'b0);
        chk("t3.clko", clko, 1'b0);
        setv(1'b0, 1'b0, 8'd0, 8'd0);
        run("t3", 3, 16'b011, 16'b100);
        // degenerate P=0,H=0 then P=5,H=9
        setv(1'b1, 1'b1, 8'd0, 8'd0);
        step();
        chk("t4a.sync_tick", tick, 1'b0);
        setv(1'b0, 1'b0, 8'd0, 8'd0);
        run("t4a", 3, 16'b000, 16'b111);
        setv(1'b1, 1'b1, 8'd5, 8'd9);
        step();
        chk("t4b.sync_tick", tick, 1'b0);
        setv(1'b0, 1'b0, 8'd0, 8'd0);
        run("t4b", 6, 16'b111111, 16'b100000);
        // enable gap at cnt=1 with a pending load
        setv(1'b1, 1'b1, 8'd3, 8'd2);
        step();
        setv(1'b0, 1'b1, 8'd4, 8'd3);
        step();
        chk("t5.pend_set", pend, 1'b1);
        setv(1'b0, 1'b0, 8'd0, 8'd0);
        en = 1'b0;
        run("t5gap", 3, 16'b000, 16'b000);
        en = 1'b1;
        run("t5", 4, 16'b0011, 16'b1000);
        // async reset with pending shadow values
        setv(1'b0, 1'b1, 8'd7, 8'd7);
        step();
        chk("t6.pend_set", pend, 1'b1);
        chk("t6.clko_pre", clko, 1'b1);
        setv(1'b0, 1'b0, 8'd0, 8'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.rst_clko", clko, 1'b0);
        chk("t6.rst_tick", tick, 1'b0);
        chk("t6.rst_pend", pend, 1'b0);
        @(negedge clki);
        rst = 1'b0;
        run("t6", 8, 16'b00110011, 16'b10001000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
